// File: rtl/sb_config_loader.sv
// sb_config_loader: serial configuration loader for the switchbox/fabric
// configuration chain. Accepts parallel bitstream words over a valid/ready
// handshake and shifts them MSB-first onto the chain, one bit per clock,
// with cfg_en high only while a bit is presented.
// Optional feature macro: SB_CFG_LOADER_CRC_EN (CRC-16-CCITT check word).
module sb_config_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cfg_data,
    output logic              cfg_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int IW = $clog2(WORD_W);
    localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORD_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
`ifdef SB_CFG_LOADER_CRC_EN
        ST_CHECK,
`endif
        ST_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [WORD_W-1:0] shreg_reg, shreg_next;       // remaining bits of current word, MSB next
    logic [CW-1:0]     bit_cnt_reg, bit_cnt_next;   // chain bits presented so far
    logic [IW-1:0]     idx_reg, idx_next;           // index of presented bit within word
    logic              cfg_data_reg, cfg_data_next;
    logic              cfg_en_reg, cfg_en_next;
    logic              word_ready_reg, word_ready_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              handshake;

    assign handshake  = word_valid && word_ready_reg;

    assign word_ready = word_ready_reg;
    assign cfg_data   = cfg_data_reg;
    assign cfg_en     = cfg_en_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

`ifdef SB_CFG_LOADER_CRC_EN
    logic [15:0] crc_reg, crc_next;
    logic [15:0] crc_word;
    logic        error_reg, error_next;

    // Low 16 bits of the check word, zero-extended for narrow words.
    for (genvar gi = 0; gi < 16; gi++) begin : g_crc_word
        if (gi < WORD_W) begin : g_bit
            assign crc_word[gi] = word_data[gi];
        end else begin : g_zero
            assign crc_word[gi] = 1'b0;
        end
    end

    // One CRC-16-CCITT step (poly 0x1021, MSB-first, no reflection).
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign error = error_reg;
`else
    assign error = 1'b0;
`endif

    // State, datapath and registered outputs; asynchronous active-low reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg      <= ST_IDLE;
            shreg_reg      <= '0;
            bit_cnt_reg    <= '0;
            idx_reg        <= '0;
            cfg_data_reg   <= 1'b0;
            cfg_en_reg     <= 1'b0;
            word_ready_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
`ifdef SB_CFG_LOADER_CRC_EN
            crc_reg        <= 16'hFFFF;
            error_reg      <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            shreg_reg      <= shreg_next;
            bit_cnt_reg    <= bit_cnt_next;
            idx_reg        <= idx_next;
            cfg_data_reg   <= cfg_data_next;
            cfg_en_reg     <= cfg_en_next;
            word_ready_reg <= word_ready_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
`ifdef SB_CFG_LOADER_CRC_EN
            crc_reg        <= crc_next;
            error_reg      <= error_next;
`endif
        end
    end

    // Next-state logic; outputs are computed for the state being entered.
    always_comb begin
        state_next      = state_reg;
        shreg_next      = shreg_reg;
        bit_cnt_next    = bit_cnt_reg;
        idx_next        = idx_reg;
        cfg_data_next   = 1'b0;
        cfg_en_next     = 1'b0;
        word_ready_next = 1'b0;
        done_next       = 1'b0;
`ifdef SB_CFG_LOADER_CRC_EN
        crc_next        = crc_reg;
        error_next      = error_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next      = ST_FETCH;
                    word_ready_next = 1'b1;
                    bit_cnt_next    = '0;
                    idx_next        = '0;
`ifdef SB_CFG_LOADER_CRC_EN
                    crc_next        = 16'hFFFF;
                    error_next      = 1'b0;
`endif
                end
            end

            ST_FETCH: begin
                word_ready_next = 1'b1;
                if (handshake) begin
                    // Present the MSB immediately; keep the rest left-aligned.
                    state_next      = ST_SHIFT;
                    word_ready_next = 1'b0;
                    cfg_en_next     = 1'b1;
                    cfg_data_next   = word_data[WORD_W-1];
                    shreg_next      = {word_data[WORD_W-2:0], 1'b0};
                    bit_cnt_next    = bit_cnt_reg + CW'(1);
                    idx_next        = '0;
                end
            end

            ST_SHIFT: begin
`ifdef SB_CFG_LOADER_CRC_EN
                crc_next = crc_step(crc_reg, cfg_data_reg);
`endif
                if (bit_cnt_reg == LAST_BIT) begin
                    // Chain full: any remaining low bits of this word are dropped.
`ifdef SB_CFG_LOADER_CRC_EN
                    state_next      = ST_CHECK;
                    word_ready_next = 1'b1;
`else
                    state_next      = ST_DONE;
                    done_next       = 1'b1;
`endif
                end else if (idx_reg == LAST_IDX) begin
                    state_next      = ST_FETCH;
                    word_ready_next = 1'b1;
                end else begin
                    cfg_en_next     = 1'b1;
                    cfg_data_next   = shreg_reg[WORD_W-1];
                    shreg_next      = {shreg_reg[WORD_W-2:0], 1'b0};
                    bit_cnt_next    = bit_cnt_reg + CW'(1);
                    idx_next        = idx_reg + IW'(1);
                end
            end

`ifdef SB_CFG_LOADER_CRC_EN
            ST_CHECK: begin
                word_ready_next = 1'b1;
                if (handshake) begin
                    state_next      = ST_DONE;
                    word_ready_next = 1'b0;
                    done_next       = 1'b1;
                    error_next      = (crc_word != crc_reg);
                end
            end
`endif

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Abort beats start and any same-cycle handshake; error is preserved.
        if (abort && state_reg != ST_IDLE) begin
            state_next      = ST_IDLE;
            cfg_en_next     = 1'b0;
            cfg_data_next   = 1'b0;
            word_ready_next = 1'b0;
            done_next       = 1'b0;
            shreg_next      = '0;
            bit_cnt_next    = '0;
            idx_next        = '0;
        end

        busy_next = (state_next != ST_IDLE);
    end

endmodule

// File: tb/tb_sb_config_loader.sv
// Testbench for sb_config_loader (CHAIN_LEN=40, WORD_W=16): table-driven
// load vectors plus hand-written sequences for latency, abort and reset.
module tb_sb_config_loader;

    localparam int CL = 40;
    localparam int WW = 16;
`ifdef SB_CFG_LOADER_CRC_EN
    localparam int CRC_ON = 1;
`else
    localparam int CRC_ON = 0;
`endif

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [WW-1:0] word_data = '0;
    logic          word_valid = 1'b0;
    logic          word_ready, cfg_data, cfg_en, busy, done, error;

    sb_config_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .abort      (abort),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .cfg_data   (cfg_data),
        .cfg_en     (cfg_en),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int stall;      // word_valid low cycles (while ready) before word 2
        int abort_at;   // bit index at which abort is raised, -1 none
        int start_at;   // bit index at which a stray start is pulsed, -1 none
        int flip;       // XOR applied to the CRC check word
        int exp_en;
        int exp_done;
        int exp_bub;
        int exp_err;
        int chk_pat;
    } vec_t;

    vec_t          vecs[6];
    logic [WW-1:0] words[4];
    logic [CL-1:0] pattern;
    logic [15:0]   crc_good;
    logic [CL-1:0] chain_sr;
    int            en_count, done_count, bubbles;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Bitwise CRC-16-CCITT reference over the chain bits in shift order.
    function automatic logic [15:0] crc_model(input logic [CL-1:0] p);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = CL - 1; i >= 0; i--) begin
            if (c[15] ^ p[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // Drive one load cycle by cycle and record what the chain would see.
    task automatic run_load(input vec_t v);
        int wi, stall_left, nwords, cyc;
        bit hs, seen_en, post_done, post_abort, fin;
        wi = 0; stall_left = v.stall; nwords = 3 + CRC_ON; cyc = 0;
        hs = 0; seen_en = 0; post_done = 0; post_abort = 0; fin = 0;
        words[3] = crc_good ^ 16'(v.flip);
        en_count = 0; done_count = 0; bubbles = 0; chain_sr = '0;
        @(negedge clk);
        start = 1'b1; word_valid = 1'b1; word_data = words[0];
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = 1'b0; abort = 1'b0;
            if (hs) wi++;
            hs = 0;
            if (post_done) begin
                chk("busy_after_done", busy, 0);
                fin = 1;
            end else if (post_abort) begin
                chk("abort_cfg_en", cfg_en, 0);
                chk("abort_busy", busy, 0);
                chk("abort_word_ready", word_ready, 0);
                chk("abort_done", done, 0);
                fin = 1;
            end else begin
                if (cfg_en) begin
                    en_count++;
                    chain_sr = {chain_sr[CL-2:0], cfg_data};
                    seen_en = 1;
                end else if (word_ready && seen_en) begin
                    bubbles++;
                end
                if (done) begin
                    done_count++;
                    chk("busy_at_done", busy, 1);
                    chk("cfg_en_at_done", cfg_en, 0);
                    chk("error_at_done", error, 64'(v.exp_err));
                    post_done = 1;
                end
                if (cfg_en && en_count == v.abort_at + 1) begin
                    abort = 1'b1;
                    post_abort = 1;
                end
                if (cfg_en && en_count == v.start_at + 1) start = 1'b1;
            end
            if (wi == 1 && stall_left > 0 && word_ready) begin
                word_valid = 1'b0;
                stall_left--;
            end else begin
                word_valid = (wi < nwords);
            end
            word_data = words[(wi < nwords) ? wi : 0];
            if (word_valid && word_ready && !abort) hs = 1;
        end
        word_valid = 1'b0; start = 1'b0; abort = 1'b0;
        if (!fin) chk("load_timeout", 0, 1);
    endtask

    initial begin
        int n;
        pattern  = 40'hA5C30FF081;
        words[0] = 16'hA5C3;
        words[1] = 16'h0FF0;
        words[2] = 16'h81FF;
        crc_good = crc_model(pattern);
        words[3] = crc_good;

        vecs[0] = '{0,  -1, -1, 0, 40, 1, 2 + CRC_ON, 0, 1};
        vecs[1] = '{5,  -1, -1, 0, 40, 1, 7 + CRC_ON, 0, 1};
        vecs[2] = '{0,  20, -1, 0, 21, 0, 1,          0, 0};
        vecs[3] = '{0,  -1, -1, 0, 40, 1, 2 + CRC_ON, 0, 1};
        vecs[4] = '{0,  -1, 10, 0, 40, 1, 2 + CRC_ON, 0, 1};
        vecs[5] = '{0,  -1, -1, 1, 40, 1, 2 + CRC_ON, CRC_ON, 1};

        // Reset state while nrst is held low.
        #3;
        chk("rst_word_ready", word_ready, 0);
        chk("rst_cfg_data", cfg_data, 0);
        chk("rst_cfg_en", cfg_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        @(negedge clk); nrst = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("idle_busy", busy, 0);
        $display("reset checks done");

        // Latency: start -> word_ready next cycle; handshake -> first bit next cycle.
        @(negedge clk);
        start = 1'b1; word_valid = 1'b1; word_data = 16'hA5C3;
        @(negedge clk);
        start = 1'b0;
        chk("lat_word_ready", word_ready, 1);
        chk("lat_busy", busy, 1);
        chk("lat_cfg_en_fetch", cfg_en, 0);
        @(negedge clk);
        chk("lat_cfg_en", cfg_en, 1);
        chk("lat_bit0", cfg_data, 1);
        chk("lat_ready_low", word_ready, 0);
        @(negedge clk);
        chk("lat_bit1", cfg_data, 0);
        word_valid = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("lat_abort_busy", busy, 0);
        $display("latency sequence done");

        // Table-driven loads.
        for (int i = 0; i < 6; i++) begin
            run_load(vecs[i]);
            chk($sformatf("v%0d_en_count", i), 64'(en_count), 64'(vecs[i].exp_en));
            chk($sformatf("v%0d_done_count", i), 64'(done_count), 64'(vecs[i].exp_done));
            chk($sformatf("v%0d_bubbles", i), 64'(bubbles), 64'(vecs[i].exp_bub));
            if (vecs[i].chk_pat != 0)
                chk($sformatf("v%0d_chain", i), 64'(chain_sr), 64'(pattern));
            $display("vector %0d: en=%0d done=%0d bubbles=%0d chain=%h", i,
                     en_count, done_count, bubbles, chain_sr);
            repeat (2) @(negedge clk);
        end

        // Error persists in IDLE and clears one cycle after the next start.
        repeat (3) @(negedge clk);
        chk("err_idle", error, 64'(CRC_ON));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_cleared", error, 0);
        chk("err_restart_ready", word_ready, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("err_abort_busy", busy, 0);
        $display("error persistence sequence done");

        // Asynchronous reset in the middle of shifting.
        @(negedge clk);
        start = 1'b1; word_valid = 1'b1; word_data = words[0];
        n = 0;
        for (int c = 0; c < 100 && n < 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (cfg_en) n++;
        end
        chk("mid_reset_reached_shift", 64'(n), 5);
        #2 nrst = 1'b0;
        #1;
        chk("arst_cfg_en", cfg_en, 0);
        chk("arst_word_ready", word_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_error", error, 0);
        @(negedge clk);
        nrst = 1'b1; word_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_ready", word_ready, 0);
        $display("async reset sequence done");

        // Full reload after reset.
        run_load(vecs[0]);
        chk("reload_en_count", 64'(en_count), 40);
        chk("reload_done_count", 64'(done_count), 1);
        chk("reload_chain", 64'(chain_sr), 64'(pattern));
        $display("reload: en=%0d done=%0d chain=%h", en_count, done_count, chain_sr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sb_config_loader.md
# sb_config_loader

Serial configuration loader that drives the configuration shift chain of the switchbox/fabric tiles. It accepts parallel bitstream words from a host or DMA through a valid/ready handshake, serializes them one bit per clock onto the chain data input, and asserts the chain shift-enable only while a bit is being presented. It sits between the bitstream source and the first tile of the configuration chain. Keeping shift-enable low outside active shifting leaves the fabric drivers enabled between and after loads.

## Interface
Parameters:
- CHAIN_LEN, 1024: total configuration bits in the attached chain (≥1).
- WORD_W, 32: bitstream word width (≥2).

Ports:
- clk  input  1  clock.
- nrst  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle request to begin a load; sampled only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE from any state.
- word_data  input  WORD_W  bitstream word.
- word_valid  input  1  word_data valid.
- word_ready  output  1  loader accepts a word this cycle.
- cfg_data  output  1  serial bit to chain config_data_in.
- cfg_en  output  1  chain shift-enable to config_en.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a load completes.
- error  output  1  sticky CRC mismatch flag (see Configuration).

## Operation
- All outputs are registered. Reset values: word_ready=0, cfg_data=0, cfg_en=0, busy=0, done=0, error=0, state=IDLE, counters=0.
- States: IDLE, FETCH, SHIFT, (CHECK when CRC is compiled in), DONE.
- IDLE: start=1 -> FETCH. start is ignored when not in IDLE. Entering FETCH from IDLE clears error.
- FETCH: word_ready=1, cfg_en=0. When word_valid && word_ready, latch the word -> SHIFT.
- SHIFT: cfg_en=1 for one cycle per bit. cfg_data presents bits MSB-first from the latched word. The first bit loaded ends up at the far end of the chain.
- Bits remaining = CHAIN_LEN − bits shifted. If CHAIN_LEN mod WORD_W ≠ 0, only the top (CHAIN_LEN mod WORD_W) bits of the final word are shifted; its low bits are discarded.
- Word count = ceil(CHAIN_LEN/WORD_W).
- After a word's last bit: if bits remain -> FETCH; else -> CHECK (CRC builds) or DONE.
- DONE: done=1 for one cycle, cfg_en=0 -> IDLE.
- abort in any non-IDLE state: next cycle cfg_en=0, word_ready=0, busy=0, no done pulse, error unchanged. abort wins over start and over a same-cycle handshake; an accepted-and-aborted word is dropped.
- The chain holds its state while cfg_en=0, so FETCH gaps do not corrupt the load.
- Counter widths: bit counter $clog2(CHAIN_LEN+1); in-word index $clog2(WORD_W). No wrap occurs within a load.

## Timing
- start at cycle t -> word_ready=1 at t+1.
- Handshake at cycle h -> cfg_en=1 and cfg_data=word[WORD_W−1] at h+1, and word[WORD_W−1−k] at h+1+k.
- Minimum one-cycle bubble per word: the cycle after a word's last SHIFT cycle is FETCH with cfg_en=0. A full word therefore costs WORD_W+1 cycles at minimum.
- Last SHIFT cycle at cycle s -> done=1 at s+1 without CRC; with CRC, the CHECK fetch follows and done pulses one cycle after the CRC word handshake.
- busy rises at t+1 and falls in the cycle after done.
- Reset mid-load: all outputs return to reset values asynchronously; the chain contents are undefined and a full reload is required.

## Configuration
- Macro SB_CFG_LOADER_CRC_EN.
- Defined:
  - A CRC-16-CCITT runs over every shifted bit in shift order: poly 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR. The CRC resets on entry to FETCH from IDLE.
  - After the last chain bit, state CHECK (word_ready=1, cfg_en=0) accepts one extra word; its low 16 bits are compared with the CRC.
  - On mismatch, error is set to 1 in the same cycle done pulses. error holds until the next start.
- Not defined: there is no CHECK state and no extra word; error is tied to 0.

## Test plan
- CHAIN_LEN=40, WORD_W=16, words 0xA5C3, 0x0FF0, 0x81FF, word_valid held high -> 40 cfg_en cycles with bit sequence A5C3,0FF0,81 (MSB-first); 0xFF low byte never shifted; exactly 2 bubble cycles; done pulses once.
- Same load with word_valid deasserted for 5 cycles before word 2 -> cfg_en stays 0 during the stall; the shifted bit sequence is identical; a 40-bit reference shift register matches the expected pattern.
- abort asserted on shift bit 20 -> cfg_en=0 and busy=0 next cycle, no done pulse; a subsequent start reloads all 40 bits correctly.
- start pulsed while busy at bit 10 -> ignored; cfg_en count stays 40 and done pulses once.
- CRC build with the correct CRC word -> error=0 at done. Same load with that CRC word's bit 0 flipped -> error=1 at done, still 1 in IDLE, cleared one cycle after the next start.
- nrst asserted during SHIFT -> cfg_en, word_ready, busy, done and error are 0 immediately; after release the block stays in IDLE until start.
